// File: rtl/fan_ctrl_pkg.sv
// Shared types and constants for the fan duty sequencer: FSM encoding,
// duty-cycle limits and the software-target clamp.
package fan_ctrl_pkg;

  localparam int DUTY_W = 8;
  localparam logic [DUTY_W-1:0] DUTY_MAX = 8'd255;
  localparam logic [DUTY_W-1:0] DUTY_OFF = 8'd0;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_KICK  = 3'd1,
    ST_RAMP  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_STALL = 3'd4
  } fan_state_e;

  // Zero means "stop"; any other request is lifted to the lowest duty the fan can sustain.
  function automatic logic [DUTY_W-1:0] clamp_target(input logic [DUTY_W-1:0] value,
                                                     input logic [DUTY_W-1:0] min_run);
    if (value == DUTY_OFF) return DUTY_OFF;
    else if (value < min_run) return min_run;
    else return value;
  endfunction

endpackage

// File: rtl/fan_period_timer.sv
// Free-running PWM period counter; period_tick marks the last clock of each period
// so it lines up with the generator's own counter wrap when both leave reset together.
module fan_period_timer #(
  parameter int PERIOD_CLKS = 256
) (
  input  logic clk,
  input  logic rst,
  output logic period_tick
);

  localparam int CNT_W = (PERIOD_CLKS > 1) ? $clog2(PERIOD_CLKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CLKS - 1);

  logic [CNT_W-1:0] count;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + 1'b1;
  end

  assign period_tick = (count == LAST);

endmodule

// File: rtl/fan_duty_sequencer.sv
// Kick-start, bounded ramp and tach-stall supervision for the fan PWM duty cycle.
module fan_duty_sequencer
  import fan_ctrl_pkg::*;
#(
  parameter int PERIOD_CLKS   = 256,
  parameter int KICK_PERIODS  = 16,
  parameter int RAMP_PERIODS  = 4,
  parameter int STEP          = 8,
  parameter int MIN_RUN_DUTY  = 40,
  parameter int STALL_PERIODS = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              target_valid,
  input  logic              tach_pulse,
  input  logic              stall_clr,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              period_tick,
  output logic [2:0]        state,
  output logic              stall
);

  localparam int KCNT_W = $clog2(KICK_PERIODS + 1);
  localparam int RCNT_W = $clog2(RAMP_PERIODS + 1);
  localparam int SCNT_W = $clog2(STALL_PERIODS + 1);
  localparam logic [KCNT_W-1:0] KICK_LAST  = KCNT_W'(KICK_PERIODS - 1);
  localparam logic [RCNT_W-1:0] RAMP_LAST  = RCNT_W'(RAMP_PERIODS - 1);
  localparam logic [SCNT_W-1:0] STALL_LAST = SCNT_W'(STALL_PERIODS - 1);
  localparam logic [DUTY_W-1:0] MIN_RUN    = DUTY_W'(MIN_RUN_DUTY);
  localparam logic [DUTY_W-1:0] STEP_D     = DUTY_W'(STEP);
  localparam logic [DUTY_W:0]   STEP_W     = (DUTY_W + 1)'(STEP);

  fan_state_e        state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d, target_q, step_duty;
  logic [KCNT_W-1:0] kick_q, kick_d;
  logic [RCNT_W-1:0] ramp_q, ramp_d;
  logic [SCNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [DUTY_W:0]   up_sum, dn_floor;
  logic              running, stall_hit;

  fan_period_timer #(.PERIOD_CLKS(PERIOD_CLKS)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .period_tick (period_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      duty_q      <= DUTY_OFF;
      target_q    <= DUTY_OFF;
      kick_q      <= '0;
      ramp_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      duty_q      <= duty_d;
      kick_q      <= kick_d;
      ramp_q      <= ramp_d;
      stall_cnt_q <= stall_cnt_d;
      if (target_valid) target_q <= clamp_target(target_duty, MIN_RUN);
    end
  end

  // One ramp step toward target, computed one bit wider so it can neither wrap nor overshoot.
  assign up_sum    = {1'b0, duty_q} + STEP_W;
  assign dn_floor  = {1'b0, target_q} + STEP_W;
  assign step_duty = (target_q > duty_q)
                   ? ((up_sum >= {1'b0, target_q}) ? target_q : up_sum[DUTY_W-1:0])
                   : (({1'b0, duty_q} <= dn_floor) ? target_q : duty_q - STEP_D);

  assign running   = (state_q == ST_RAMP) || (state_q == ST_HOLD);
  assign stall_hit = running && period_tick && !tach_pulse && (stall_cnt_q == STALL_LAST);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    duty_d      = duty_q;
    kick_d      = kick_q;
    ramp_d      = ramp_q;
    stall_cnt_d = stall_cnt_q;

    if (!running || tach_pulse) stall_cnt_d = '0;
    else if (period_tick)       stall_cnt_d = stall_cnt_q + 1'b1;

    if (stall_hit) begin
      state_d = ST_STALL;
      duty_d  = DUTY_OFF;
    end else if (!enable && (state_q inside {ST_KICK, ST_RAMP, ST_HOLD})) begin
      state_d = ST_OFF;
      duty_d  = DUTY_OFF;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          duty_d = DUTY_OFF;
          if (period_tick && enable && target_q != DUTY_OFF) begin
            state_d = ST_KICK;
            duty_d  = DUTY_MAX;
            kick_d  = '0;
          end
        end
        ST_KICK: begin
          duty_d = DUTY_MAX;
          if (period_tick) begin
            if (kick_q == KICK_LAST) begin
              state_d = ST_RAMP;
              duty_d  = MIN_RUN;
              ramp_d  = '0;
            end else begin
              kick_d = kick_q + 1'b1;
            end
          end
        end
        ST_RAMP: begin
          if (target_q == DUTY_OFF) begin
            state_d = ST_OFF;
            duty_d  = DUTY_OFF;
          end else if (duty_q == target_q) begin
            state_d = ST_HOLD;
          end else if (period_tick) begin
            if (ramp_q == RAMP_LAST) begin
              ramp_d = '0;
              duty_d = step_duty;
              if (step_duty == target_q) state_d = ST_HOLD;
            end else begin
              ramp_d = ramp_q + 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (target_q == DUTY_OFF) begin
            state_d = ST_OFF;
            duty_d  = DUTY_OFF;
          end else if (target_q != duty_q) begin
            state_d = ST_RAMP;
            ramp_d  = '0;
          end
        end
        ST_STALL: begin
          duty_d = DUTY_OFF;
          if (stall_clr) state_d = ST_OFF;
        end
        default: begin
          state_d = ST_OFF;
          duty_d  = DUTY_OFF;
        end
      endcase
    end
  end

  always_comb begin
    duty_cycle = duty_q;
    state      = state_q;
    stall      = (state_q == ST_STALL);
  end

endmodule

// File: tb/tb_fan_duty_sequencer.sv
// Directed bench for fan_duty_sequencer with short periods; the bench tracks the
// period phase itself and drives one tach pulse on the last clock of every period.
module tb_fan_duty_sequencer;

  localparam logic [2:0] S_OFF = 3'd0, S_KICK = 3'd1, S_RAMP = 3'd2, S_HOLD = 3'd3, S_STALL = 3'd4;

  logic       clk = 1'b0;
  logic       rst, enable, target_valid, tach_pulse, stall_clr;
  logic [7:0] target_duty;
  logic [7:0] duty_cycle;
  logic       period_tick, stall;
  logic [2:0] state;

  int n_checks = 0;
  int n_fail   = 0;
  int phase    = 0;
  bit tach_on  = 1'b1;

  always #5 clk = ~clk;

  fan_duty_sequencer #(
    .PERIOD_CLKS(8), .KICK_PERIODS(2), .RAMP_PERIODS(1),
    .STEP(16), .MIN_RUN_DUTY(40), .STALL_PERIODS(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .target_duty  (target_duty),
    .target_valid (target_valid),
    .tach_pulse   (tach_pulse),
    .stall_clr    (stall_clr),
    .duty_cycle   (duty_cycle),
    .period_tick  (period_tick),
    .state        (state),
    .stall        (stall)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock; strobes are single-cycle, phase mirrors the DUT period counter.
  task automatic clk1();
    tach_pulse = tach_on && (phase == 7);
    @(posedge clk);
    #1;
    phase        = (phase + 1) % 8;
    target_valid = 1'b0;
    stall_clr    = 1'b0;
    tach_pulse   = 1'b0;
  endtask

  task automatic next_period();
    do clk1(); while (phase != 0);
  endtask

  task automatic to_phase(input int p);
    while (phase != p) clk1();
  endtask

  task automatic load(input logic [7:0] t);
    target_duty  = t;
    target_valid = 1'b1;
    clk1();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; target_duty = 8'd0; target_valid = 1'b0;
    tach_pulse = 1'b0; stall_clr = 1'b0;
    clk1(); clk1();
    check("rst_duty", duty_cycle, 0);
    check("rst_state", state, S_OFF);
    check("rst_stall", stall, 0);
    check("rst_tick", period_tick, 0);
    rst = 1'b0; phase = 0;

    // Spin-up: kick at 255 for two periods, then ramp 40..100 in steps of 16.
    enable = 1'b1;
    load(8'd100);
    check("t1_wait_tick", state, S_OFF);
    to_phase(7);
    check("t1_tick_last", period_tick, 1);
    clk1();
    check("t1_kick_state", state, S_KICK);
    check("t1_kick_duty", duty_cycle, 255);
    to_phase(4);
    check("t1_kick_mid", duty_cycle, 255);
    next_period();
    check("t1_kick2_duty", duty_cycle, 255);
    next_period();
    check("t1_ramp_state", state, S_RAMP);
    check("t1_ramp40", duty_cycle, 40);
    next_period(); check("t1_ramp56", duty_cycle, 56);
    to_phase(5);   check("t1_ramp56_mid", duty_cycle, 56);
    next_period(); check("t1_ramp72", duty_cycle, 72);
    next_period(); check("t1_ramp88", duty_cycle, 88);
    next_period();
    check("t1_sat100", duty_cycle, 100);
    check("t1_hold", state, S_HOLD);
    stall_clr = 1'b1; clk1();
    check("t1_clr_ignored_state", state, S_HOLD);
    check("t1_clr_ignored_duty", duty_cycle, 100);

    // Low target clamps to 40; ramp down 84, 68, 52, 40.
    load(8'd10);
    check("t2_load_state", state, S_HOLD);
    clk1();
    check("t2_reramp_state", state, S_RAMP);
    check("t2_reramp_duty", duty_cycle, 100);
    next_period(); check("t2_dn84", duty_cycle, 84);
    next_period(); check("t2_dn68", duty_cycle, 68);
    next_period(); check("t2_dn52", duty_cycle, 52);
    next_period();
    check("t2_dn40", duty_cycle, 40);
    check("t2_hold", state, S_HOLD);

    // Tach stops: stall after the fourth period without a pulse.
    tach_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_period();
      check("t4_pre_stall", state, S_HOLD);
    end
    next_period();
    check("t4_stall_state", state, S_STALL);
    check("t4_stall_duty", duty_cycle, 0);
    check("t4_stall_flag", stall, 1);
    enable = 1'b0; clk1(); clk1();
    check("t4_dis_state", state, S_STALL);
    check("t4_dis_flag", stall, 1);
    enable = 1'b1; next_period();
    check("t4_en_state", state, S_STALL);
    stall_clr = 1'b1; clk1();
    check("t4_clr_state", state, S_OFF);
    check("t4_clr_flag", stall, 0);
    check("t4_clr_duty", duty_cycle, 0);

    // No tach through kick and two ramp ticks: kick periods must not count toward stall.
    load(8'd100);
    next_period(); check("t5_kick", state, S_KICK);
    next_period();
    next_period(); check("t5_ramp40", duty_cycle, 40);
    next_period();
    next_period();
    check("t5_no_kick_count", state, S_RAMP);
    check("t5_ramp72", duty_cycle, 72);
    tach_on = 1'b1;
    next_period();
    next_period();
    check("t5_hold100", state, S_HOLD);
    // Tach returns exactly on the threshold tick.
    tach_on = 1'b0;
    next_period(); next_period(); next_period();
    tach_on = 1'b1;
    next_period();
    check("t5_coincident_state", state, S_HOLD);
    check("t5_coincident_flag", stall, 0);
    next_period();
    check("t5_after_state", state, S_HOLD);

    // Forced-off cases mid-ramp.
    load(8'd60);
    clk1();
    next_period();
    check("t3_midramp84", duty_cycle, 84);
    load(8'd0);
    check("t3_zero_lat1_state", state, S_RAMP);
    clk1();
    check("t3_zero_off_state", state, S_OFF);
    check("t3_zero_off_duty", duty_cycle, 0);
    load(8'd100);
    next_period();
    check("t3_rekick_state", state, S_KICK);
    check("t3_rekick_duty", duty_cycle, 255);
    next_period(); next_period(); next_period();
    check("t3_ramp56", duty_cycle, 56);
    to_phase(7);
    enable = 1'b0; clk1();
    check("t3_dis_state", state, S_OFF);
    check("t3_dis_duty", duty_cycle, 0);
    enable = 1'b1;
    next_period();
    check("t3_reen_state", state, S_KICK);

    // Reset mid-kick.
    to_phase(3);
    rst = 1'b1; clk1();
    check("t6_duty", duty_cycle, 0);
    check("t6_state", state, S_OFF);
    check("t6_stall", stall, 0);
    check("t6_tick", period_tick, 0);
    rst = 1'b0; phase = 0;
    to_phase(6);
    check("t6_tick_ph6", period_tick, 0);
    clk1();
    check("t6_tick_ph7", period_tick, 1);
    next_period();
    check("t6_target_cleared", state, S_OFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
